// File: rtl/lit_pkg.sv
// Shared constants for the LIT 3x3 window stage: default sample width, tap
// numbering and RGB packing helpers.
package lit_pkg;

    localparam int PIX_BIT_DEF = 9;
    localparam int N_CH        = 3;
    localparam int N_TAP       = 9;

    // Taps in raster order: 1 top-left .. 9 bottom-right, 5 is the centre.
    localparam int TAP_TL = 1;
    localparam int TAP_TC = 2;
    localparam int TAP_TR = 3;
    localparam int TAP_ML = 4;
    localparam int TAP_C  = 5;
    localparam int TAP_MR = 6;
    localparam int TAP_BL = 7;
    localparam int TAP_BC = 8;
    localparam int TAP_BR = 9;

    // Channel index; channel ch lives at bits [ch*PIX_BIT +: PIX_BIT] of a packed pixel.
    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } chan_e;

    function automatic int rgb_bits(input int pix_bit);
        return N_CH * pix_bit;
    endfunction

endpackage

// File: rtl/lit_window_3x3_if.sv
// Pixel-in / window-out bundle of the LIT 3x3 window generator.
// pix_valid qualifies sof and the RGB inputs; there is no ready: every valid pixel is
// taken, and the consumer must accept each window in the single cycle win_valid is high.
interface lit_window_3x3_if
    import lit_pkg::*;
#(
    parameter int PIX_BIT = PIX_BIT_DEF
);
    logic               pix_valid;
    logic               sof;
    logic [PIX_BIT-1:0] R_IN, G_IN, B_IN;

    logic [PIX_BIT-1:0] R1_OUT, R2_OUT, R3_OUT, R4_OUT, R5_OUT, R6_OUT, R7_OUT, R8_OUT, R9_OUT;
    logic [PIX_BIT-1:0] G1_OUT, G2_OUT, G3_OUT, G4_OUT, G5_OUT, G6_OUT, G7_OUT, G8_OUT, G9_OUT;
    logic [PIX_BIT-1:0] B1_OUT, B2_OUT, B3_OUT, B4_OUT, B5_OUT, B6_OUT, B7_OUT, B8_OUT, B9_OUT;
    logic               win_valid;
    logic               frame_done;

    modport master (
        output pix_valid, sof, R_IN, G_IN, B_IN,
        input  R1_OUT, R2_OUT, R3_OUT, R4_OUT, R5_OUT, R6_OUT, R7_OUT, R8_OUT, R9_OUT,
        input  G1_OUT, G2_OUT, G3_OUT, G4_OUT, G5_OUT, G6_OUT, G7_OUT, G8_OUT, G9_OUT,
        input  B1_OUT, B2_OUT, B3_OUT, B4_OUT, B5_OUT, B6_OUT, B7_OUT, B8_OUT, B9_OUT,
        input  win_valid, frame_done
    );

    modport slave (
        input  pix_valid, sof, R_IN, G_IN, B_IN,
        output R1_OUT, R2_OUT, R3_OUT, R4_OUT, R5_OUT, R6_OUT, R7_OUT, R8_OUT, R9_OUT,
        output G1_OUT, G2_OUT, G3_OUT, G4_OUT, G5_OUT, G6_OUT, G7_OUT, G8_OUT, G9_OUT,
        output B1_OUT, B2_OUT, B3_OUT, B4_OUT, B5_OUT, B6_OUT, B7_OUT, B8_OUT, B9_OUT,
        output win_valid, frame_done
    );

endinterface

// File: rtl/lit_line_buffer.sv
// Two-row line buffer: one word per column holding {row-2, row-1} RGB pixels.
// Reads are combinational so the caller sees the old word in the same cycle it writes the new one.
module lit_line_buffer #(
    parameter int RGB_W = 27,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [RGB_W-1:0] din,
    output logic [RGB_W-1:0] row1,
    output logic [RGB_W-1:0] row2
);

    logic [2*RGB_W-1:0] mem [DEPTH];
    logic [2*RGB_W-1:0] rd_word;

    assign rd_word = mem[addr];
    assign row1    = rd_word[RGB_W-1:0];
    assign row2    = rd_word[2*RGB_W-1:RGB_W];

    // Row-1 ages into row-2 and the incoming pixel becomes the new row-1.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= {row1, din};
        end
    end

endmodule

// File: rtl/lit_window_3x3.sv
// Streaming 3x3 RGB neighbourhood generator: raster pixels in, fully-interior windows out
// one cycle after the pixel that completes them (that pixel is tap 9).
module lit_window_3x3
    import lit_pkg::*;
#(
    parameter int PIX_BIT = PIX_BIT_DEF,
    parameter int IMG_W   = 64,
    parameter int IMG_H   = 64,
    parameter int CNT_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    lit_window_3x3_if.slave bus
);

    localparam int                 RGB_W    = rgb_bits(PIX_BIT);
    localparam int                 AW       = $clog2(IMG_W);
    localparam logic [CNT_BIT-1:0] COL_LAST = CNT_BIT'(IMG_W - 1);
    localparam logic [CNT_BIT-1:0] ROW_LAST = CNT_BIT'(IMG_H - 1);
    localparam logic [CNT_BIT-1:0] EDGE     = CNT_BIT'(2);

    logic [CNT_BIT-1:0] col_q, row_q;
    logic [CNT_BIT-1:0] col_cur, row_cur;
    logic [CNT_BIT-1:0] col_nxt, row_nxt;
    logic               accept;
    logic [RGB_W-1:0]   pix_in;
    logic [RGB_W-1:0]   lb_row1, lb_row2;
    logic [PIX_BIT-1:0] tap [0:N_CH-1][1:N_TAP];
    logic               win_valid_q;
    logic               frame_done_q;

    assign accept = bus.pix_valid;
    assign pix_in = {bus.B_IN, bus.G_IN, bus.R_IN};

    // sof relabels the current pixel as (0,0) without waiting for the counters.
    always_comb begin
        col_cur = bus.sof ? '0 : col_q;
        row_cur = bus.sof ? '0 : row_q;
        col_nxt = col_cur + CNT_BIT'(1);
        row_nxt = row_cur;
        if (col_cur == COL_LAST) begin
            col_nxt = '0;
            row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + CNT_BIT'(1);
        end
    end

    lit_line_buffer #(
        .RGB_W (RGB_W),
        .DEPTH (IMG_W),
        .AW    (AW)
    ) u_line_buffer (
        .clk  (clk),
        .we   (accept),
        .addr (col_cur[AW-1:0]),
        .din  (pix_in),
        .row1 (lb_row1),
        .row2 (lb_row2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            tap          <= '{default: '0};
        end else begin
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (accept) begin
                col_q        <= col_nxt;
                row_q        <= row_nxt;
                win_valid_q  <= (col_cur >= EDGE) && (row_cur >= EDGE);
                frame_done_q <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
                // Window slides left one column; the right column is {row-2, row-1, input}.
                for (int ch = 0; ch < N_CH; ch++) begin
                    tap[ch][TAP_TL] <= tap[ch][TAP_TC];
                    tap[ch][TAP_TC] <= tap[ch][TAP_TR];
                    tap[ch][TAP_TR] <= lb_row2[ch*PIX_BIT +: PIX_BIT];
                    tap[ch][TAP_ML] <= tap[ch][TAP_C];
                    tap[ch][TAP_C]  <= tap[ch][TAP_MR];
                    tap[ch][TAP_MR] <= lb_row1[ch*PIX_BIT +: PIX_BIT];
                    tap[ch][TAP_BL] <= tap[ch][TAP_BC];
                    tap[ch][TAP_BC] <= tap[ch][TAP_BR];
                    tap[ch][TAP_BR] <= pix_in[ch*PIX_BIT +: PIX_BIT];
                end
            end
        end
    end

    assign bus.win_valid  = win_valid_q;
    assign bus.frame_done = frame_done_q;

    assign bus.R1_OUT = tap[CH_R][TAP_TL];
    assign bus.R2_OUT = tap[CH_R][TAP_TC];
    assign bus.R3_OUT = tap[CH_R][TAP_TR];
    assign bus.R4_OUT = tap[CH_R][TAP_ML];
    assign bus.R5_OUT = tap[CH_R][TAP_C];
    assign bus.R6_OUT = tap[CH_R][TAP_MR];
    assign bus.R7_OUT = tap[CH_R][TAP_BL];
    assign bus.R8_OUT = tap[CH_R][TAP_BC];
    assign bus.R9_OUT = tap[CH_R][TAP_BR];

    assign bus.G1_OUT = tap[CH_G][TAP_TL];
    assign bus.G2_OUT = tap[CH_G][TAP_TC];
    assign bus.G3_OUT = tap[CH_G][TAP_TR];
    assign bus.G4_OUT = tap[CH_G][TAP_ML];
    assign bus.G5_OUT = tap[CH_G][TAP_C];
    assign bus.G6_OUT = tap[CH_G][TAP_MR];
    assign bus.G7_OUT = tap[CH_G][TAP_BL];
    assign bus.G8_OUT = tap[CH_G][TAP_BC];
    assign bus.G9_OUT = tap[CH_G][TAP_BR];

    assign bus.B1_OUT = tap[CH_B][TAP_TL];
    assign bus.B2_OUT = tap[CH_B][TAP_TC];
    assign bus.B3_OUT = tap[CH_B][TAP_TR];
    assign bus.B4_OUT = tap[CH_B][TAP_ML];
    assign bus.B5_OUT = tap[CH_B][TAP_C];
    assign bus.B6_OUT = tap[CH_B][TAP_MR];
    assign bus.B7_OUT = tap[CH_B][TAP_BL];
    assign bus.B8_OUT = tap[CH_B][TAP_BC];
    assign bus.B9_OUT = tap[CH_B][TAP_BR];

endmodule

// File: tb/tb_lit_window_3x3.sv
// Bench for lit_window_3x3 on an 8x4 frame with samples R=16*row+col(+offset), G=R+128, B=R+256.
module tb_lit_window_3x3;
    import lit_pkg::*;

    localparam int PB = 9;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int CB = 8;
    localparam int EW = 27 * PB + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    lit_window_3x3_if #(.PIX_BIT(PB)) bus ();

    lit_window_3x3 #(
        .PIX_BIT (PB),
        .IMG_W   (W),
        .IMG_H   (H),
        .CNT_BIT (CB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int               checks  = 0;
    int               errors  = 0;
    int               win_cnt = 0;
    logic             pend    = 1'b0;
    logic [EW-1:0]    exp_q[$];
    logic [9*PB-1:0]  win_log[$];
    logic [EW-1:0]    mon_want;
    logic [27*PB-1:0] got_taps;

    assign got_taps = {bus.B9_OUT, bus.B8_OUT, bus.B7_OUT, bus.B6_OUT, bus.B5_OUT,
                       bus.B4_OUT, bus.B3_OUT, bus.B2_OUT, bus.B1_OUT,
                       bus.G9_OUT, bus.G8_OUT, bus.G7_OUT, bus.G6_OUT, bus.G5_OUT,
                       bus.G4_OUT, bus.G3_OUT, bus.G2_OUT, bus.G1_OUT,
                       bus.R9_OUT, bus.R8_OUT, bus.R7_OUT, bus.R6_OUT, bus.R5_OUT,
                       bus.R4_OUT, bus.R3_OUT, bus.R2_OUT, bus.R1_OUT};

    typedef struct {
        int              idx;
        logic [9*PB-1:0] r;
    } win_vec_t;

    win_vec_t vecs[8];

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic logic [9*PB-1:0] pack9(input int a1, input int a2, input int a3,
                                              input int a4, input int a5, input int a6,
                                              input int a7, input int a8, input int a9);
        return {PB'(a9), PB'(a8), PB'(a7), PB'(a6), PB'(a5), PB'(a4), PB'(a3), PB'(a2), PB'(a1)};
    endfunction

    // Expected window for the pixel at (c,r): rows r-2..r, columns c-2..c, all channels.
    function automatic logic [EW-1:0] exp_word(input int c, input int r, input int off);
        logic [EW-1:0] w = '0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 1; k <= 9; k++) begin
                int px = c - 2 + (k - 1) % 3;
                int py = r - 2 + (k - 1) / 3;
                w[(ch*9 + k - 1)*PB +: PB] = PB'(16*py + px + off + 128*ch);
            end
        end
        w[EW-1] = (c == W - 1) && (r == H - 1);
        return w;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        pend          = 1'b0;
    endtask

    task automatic send_pix(input int c, input int r, input bit s, input int off);
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.sof       = s;
        bus.R_IN      = PB'(16*r + c + off);
        bus.G_IN      = PB'(16*r + c + off + 128);
        bus.B_IN      = PB'(16*r + c + off + 256);
        pend          = (c >= 2) && (r >= 2);
        if (pend) exp_q.push_back(exp_word(c, r, off));
    endtask

    task automatic send_frame(input int off, input bit use_sof, input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
                send_pix(c, r, use_sof && (c == 0) && (r == 0), off);
            end
        end
    endtask

    task automatic drain(input string name, input int want_wins);
        repeat (3) idle_cycle();
        check_int({name, "_win_count"}, win_cnt, want_wins);
        check_int({name, "_exp_left"}, exp_q.size(), 0);
    endtask

    // Monitor: every cycle win_valid must match the pixel accepted on the previous edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                check_int("win_valid_timing", int'(bus.win_valid), int'(pend));
                check_int("frame_done_alone", int'(bus.frame_done === 1'b1 && bus.win_valid !== 1'b1), 0);
                if (bus.win_valid === 1'b1) begin
                    logic xt_ok;
                    win_cnt++;
                    win_log.push_back(got_taps[9*PB-1:0]);
                    xt_ok = 1'b1;
                    for (int k = 0; k < 9; k++) begin
                        if (got_taps[(9 + k)*PB +: PB] !== got_taps[k*PB +: PB] + PB'(128)) xt_ok = 1'b0;
                        if (got_taps[(18 + k)*PB +: PB] !== got_taps[k*PB +: PB] + PB'(256)) xt_ok = 1'b0;
                    end
                    check_int("gb_crosstalk", int'(xt_ok), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window got=%0h want=none", got_taps);
                    end else begin
                        mon_want = exp_q.pop_front();
                        check("window_taps", {bus.frame_done, got_taps}, mon_want);
                    end
                end
            end
        end
    end

    initial begin
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.R_IN      = '0;
        bus.G_IN      = '0;
        bus.B_IN      = '0;

        vecs[0] = '{0,  pack9(0, 1, 2, 16, 17, 18, 32, 33, 34)};
        vecs[1] = '{6,  pack9(16, 17, 18, 32, 33, 34, 48, 49, 50)};
        vecs[2] = '{11, pack9(21, 22, 23, 37, 38, 39, 53, 54, 55)};
        vecs[3] = '{12, pack9(0, 1, 2, 16, 17, 18, 32, 33, 34)};
        vecs[4] = '{23, pack9(21, 22, 23, 37, 38, 39, 53, 54, 55)};
        vecs[5] = '{24, pack9(0, 1, 2, 16, 17, 18, 32, 33, 34)};
        vecs[6] = '{36, pack9(1, 2, 3, 17, 18, 19, 33, 34, 35)};
        vecs[7] = '{47, pack9(22, 23, 24, 38, 39, 40, 54, 55, 56)};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_taps", {bus.frame_done, got_taps}, '0);
        check_int("reset_win_valid", int'(bus.win_valid), 0);
        rst = 1'b1;

        // 1: full frame at full rate
        win_log.delete();
        win_cnt = 0;
        send_frame(0, 1'b1, 1'b0);
        drain("t1", 12);

        // 2: same frame with random gaps
        win_cnt = 0;
        send_frame(0, 1'b1, 1'b1);
        drain("t2", 12);

        // 3: two back-to-back frames, second offset by +1
        win_cnt = 0;
        send_frame(0, 1'b1, 1'b0);
        send_frame(1, 1'b0, 1'b0);
        drain("t3", 24);

        check_int("window_log_size", win_log.size(), 48);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].idx < win_log.size())
                check($sformatf("table_win_%0d", vecs[i].idx), EW'(win_log[vecs[i].idx]), EW'(vecs[i].r));
            else
                check_int($sformatf("table_win_%0d_missing", vecs[i].idx), win_log.size(), vecs[i].idx + 1);
        end

        // 4: sof restarts the frame at what would have been pixel (5,2)
        win_cnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 2 && c == 5) break;
                send_pix(c, r, 1'b0, 0);
            end
        end
        send_frame(2, 1'b1, 1'b0);
        drain("t4", 15);

        // 5: reset pulse at pixel (4,3), then a frame with no sof
        win_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == 3 && c == 4) break;
                send_pix(c, r, 1'b0, 0);
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
        pend          = 1'b0;
        rst           = 1'b0;
        @(posedge clk);
        #2;
        check_int("t5_pre_reset_wins", win_cnt, 8);
        check("t5_reset_taps", {bus.frame_done, got_taps}, '0);
        check_int("t5_reset_win_valid", int'(bus.win_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        win_cnt = 0;
        send_frame(3, 1'b0, 1'b0);
        drain("t5", 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
